// File: rtl/dmg_pkg.sv
// -----------------------------------------------------------------------------
// dmg_pkg
// Shared types and constants for the DMG video path.
//   fb_state_t : framebuffer writer control states
//   fb_wr_t    : one framebuffer write {addr, data}
//   LCD_W/H    : active LCD geometry in pixels/lines
// -----------------------------------------------------------------------------
package dmg_pkg;

   localparam int LCD_W     = 160;
   localparam int LCD_H     = 144;
   localparam int FB_ADDR_W = 14;

   typedef enum logic [1:0] {
      WAIT_FRAME = 2'd0,
      ACTIVE     = 2'd1,
      DRAIN      = 2'd2
   } fb_state_t;

   typedef struct packed {
      logic [FB_ADDR_W-1:0] addr;
      logic [7:0]           data;
   } fb_wr_t;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a registered head: dout always holds the oldest entry
// and is valid whenever empty is low. A read pops that entry. A write into a
// full FIFO is accepted only if a read happens in the same cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en, din : write request and data
//   rd_en      : pop the head entry (ignored while empty)
//   dout       : head entry, registered
//   full/empty : occupancy flags
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] din,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_nxt;
   logic [AW:0]      count, count_left;
   logic             do_rd, do_wr;
   logic [WIDTH-1:0] head_nxt;

   assign empty = (count == '0);
   assign full  = (count == (AW+1)'(DEPTH));

   assign do_rd = rd_en && !empty;
   assign do_wr = wr_en && (!full || do_rd);

   assign rd_ptr_nxt = rd_ptr + AW'(do_rd);
   assign count_left = count - (AW+1)'(do_rd);
   // When the FIFO would otherwise be empty, the incoming word becomes the
   // head directly instead of waiting a cycle to be read back from mem.
   assign head_nxt   = (count_left == '0) ? din : mem[rd_ptr_nxt];

   // NOTE: storage has no reset; only pointers and count need a known value,
   // and leaving the array unreset lets it map onto plain RAM cells.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= din;
   end

   // NOTE: sequential state is always assigned with <= so every flop samples
   // the pre-edge values of its neighbours, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         dout   <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(do_wr);
         rd_ptr <= rd_ptr_nxt;
         count  <= count_left + (AW+1)'(do_wr);
         // Head only moves on a pop or on the first write into an empty
         // queue, so it stays stable while the consumer stalls.
         if (count_left != '0 || do_wr) dout <= head_nxt;
      end
   end

endmodule

// File: rtl/lcd_fb_writer.sv
// -----------------------------------------------------------------------------
// lcd_fb_writer
// Packs the PPU 2bpp pixel stream four pixels per byte and writes it into a
// double-buffered framebuffer. Banks swap only after a whole frame has been
// written and drained, so scan-out always reads a complete frame.
//   clk, rst_n            : clock, asynchronous active-low reset
//   lcd_pixel, lcd_color  : pixel strobe and 2-bit shade
//   lcd_hsync, lcd_vsync  : end-of-line / start-of-frame pulses
//   fb_addr, fb_data      : write {bank, offset} and packed byte
//   fb_valid, fb_ready    : write handshake, transfer on valid && ready
//   disp_bank             : bank holding the last complete frame
//   frame_done            : 1-cycle pulse on bank swap
//   err_overrun, clr_err  : sticky error flag and its clear
// -----------------------------------------------------------------------------
module lcd_fb_writer
   import dmg_pkg::*;
#(
   parameter int H_PIXELS   = LCD_W,
   parameter int V_LINES    = LCD_H,
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = FB_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              lcd_pixel,
   input  logic [1:0]        lcd_color,
   input  logic              lcd_hsync,
   input  logic              lcd_vsync,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [7:0]        fb_data,
   output logic              fb_valid,
   input  logic              fb_ready,
   output logic              disp_bank,
   output logic              frame_done,
   output logic              err_overrun,
   input  logic              clr_err
);

   localparam int XW   = $clog2(H_PIXELS + 1);
   localparam int YW   = $clog2(V_LINES + 1);
   localparam int OW   = ADDR_W - 1;
   localparam int WR_W = ADDR_W + 8;

   fb_state_t       state, state_nxt;
   logic [XW-1:0]   x;
   logic [YW-1:0]   y;
   logic [OW-1:0]   line_base;     // y * (H_PIXELS/4), kept as a running sum
   logic [7:0]      pack, pack_nxt;
   logic            wr_bank;
   logic            push_valid;
   logic [WR_W-1:0] push_word;

   logic            fifo_full, fifo_empty, pop;
   logic [WR_W-1:0] fifo_dout;

   logic            in_active, vsync_evt, pix_evt, pix_drop, hsync_evt;
   logic            last_line, byte_done, push_req, swap, extra_line;
   logic            overflow, set_err;

   // Event qualification: vsync masks any coincident pixel or hsync.
   assign in_active  = (state == ACTIVE);
   assign vsync_evt  = lcd_vsync && (state != DRAIN);
   assign pix_evt    = in_active && lcd_pixel && !lcd_vsync && (x < XW'(H_PIXELS));
   assign pix_drop   = in_active && lcd_pixel && !lcd_vsync && (x >= XW'(H_PIXELS));
   assign hsync_evt  = in_active && lcd_hsync && !lcd_vsync;
   assign last_line  = (y == YW'(V_LINES - 1));
   // Line activity after the final line of a frame means too many lines.
   assign extra_line = (state == DRAIN) && (lcd_pixel || lcd_hsync) && !lcd_vsync;

   // A coincident pixel belongs to the line that hsync ends, so it is merged
   // into the byte before any flush. A flush is needed only when the line
   // leaves a partial byte behind.
   assign byte_done = pix_evt && (x[1:0] == 2'd3);
   assign push_req  = byte_done || (hsync_evt && (pix_evt || x[1:0] != 2'd0));

   assign swap = (state == DRAIN) && fifo_empty && !push_valid;

   assign pop      = fb_valid && fb_ready;
   assign overflow = push_valid && fifo_full && !pop;
   assign set_err  = pix_drop || overflow || extra_line;

   // Pixel x%4 lands in bits [2*(x%4)+1 : 2*(x%4)]; unwritten bits stay zero
   // because pack is cleared after every push.
   always_comb begin
      // NOTE: default first, so no path through this block leaves pack_nxt
      // unassigned and infers a latch.
      pack_nxt = pack;
      if (pix_evt) pack_nxt[{x[1:0], 1'b0} +: 2] = lcd_color;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         WAIT_FRAME: if (lcd_vsync)              state_nxt = ACTIVE;
         ACTIVE:     if (hsync_evt && last_line) state_nxt = DRAIN;
         DRAIN:      if (swap)                   state_nxt = WAIT_FRAME;
         default:                                state_nxt = WAIT_FRAME;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= WAIT_FRAME;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x           <= '0;
         y           <= '0;
         line_base   <= '0;
         pack        <= '0;
         push_valid  <= 1'b0;
         push_word   <= '0;
         wr_bank     <= 1'b1;
         disp_bank   <= 1'b0;
         frame_done  <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         // A vsync in ACTIVE abandons the partial frame; whatever is already
         // queued still drains into the current write bank.
         if (vsync_evt) begin
            x         <= '0;
            y         <= '0;
            line_base <= '0;
         end else if (hsync_evt) begin
            x         <= '0;
            y         <= y + YW'(1);
            line_base <= line_base + OW'(H_PIXELS / 4);
         end else if (pix_evt) begin
            x <= x + XW'(1);
         end

         pack       <= (push_req || vsync_evt) ? '0 : pack_nxt;
         push_valid <= push_req;
         if (push_req) push_word <= {wr_bank, line_base + OW'(x >> 2), pack_nxt};

         if (swap) begin
            disp_bank <= wr_bank;
            wr_bank   <= ~wr_bank;
         end
         frame_done <= swap;

         if (set_err)      err_overrun <= 1'b1;
         else if (clr_err) err_overrun <= 1'b0;
      end
   end

   sync_fifo #(
      .WIDTH (WR_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_en (push_valid),
      .din   (push_word),
      .rd_en (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign fb_valid          = !fifo_empty;
   assign {fb_addr, fb_data} = fifo_dout;

endmodule

// File: tb/tb_lcd_fb_writer.sv
// -----------------------------------------------------------------------------
// tb_lcd_fb_writer
// Directed sequence with randomized pixel data and fb_ready stalls. Expected
// framebuffer writes come from a line-level model: each line of shades is
// folded into bytes (four pixels per byte, low bits first) at address
// {bank, y*40 + byte index}, truncated to 160 pixels.
// -----------------------------------------------------------------------------
module tb_lcd_fb_writer;

   localparam int H  = 160;
   localparam int V  = 144;
   localparam int AW = 14;

   typedef int iq_t[$];

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          lcd_pixel = 1'b0;
   logic [1:0]    lcd_color = 2'd0;
   logic          lcd_hsync = 1'b0;
   logic          lcd_vsync = 1'b0;
   logic          fb_ready = 1'b1;
   logic          clr_err = 1'b0;
   logic [AW-1:0] fb_addr;
   logic [7:0]    fb_data;
   logic          fb_valid, disp_bank, frame_done, err_overrun;

   always #5 clk = ~clk;

   lcd_fb_writer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .lcd_pixel   (lcd_pixel),
      .lcd_color   (lcd_color),
      .lcd_hsync   (lcd_hsync),
      .lcd_vsync   (lcd_vsync),
      .fb_addr     (fb_addr),
      .fb_data     (fb_data),
      .fb_valid    (fb_valid),
      .fb_ready    (fb_ready),
      .disp_bank   (disp_bank),
      .frame_done  (frame_done),
      .err_overrun (err_overrun),
      .clr_err     (clr_err)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- fb_ready driver ----------------
   int   ready_mode  = 0;     // 0: fixed level, 1: random stalls
   logic ready_fixed = 1'b1;
   int   low_run     = 0;

   // Random mode never holds ready low for more than 3 cycles, so the drain
   // keeps pace with the fastest possible byte rate and cannot overflow.
   always @(posedge clk) begin
      #1;
      if (ready_mode == 1) begin
         if (low_run >= 3 || $urandom_range(0, 3) != 0) begin
            fb_ready = 1'b1;
            low_run  = 0;
         end else begin
            fb_ready = 1'b0;
            low_run++;
         end
      end else begin
         fb_ready = ready_fixed;
      end
   end

   // ---------------- monitor ----------------
   logic [21:0] obs_q[$];
   logic [21:0] exp_q[$];
   int          cyc = 0, fd_count = 0, fd_cycle = 0, last_xfer = 0;
   logic        stall_prev = 1'b0;
   logic [22:0] stall_val = '0;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev)
            check("stall_hold", 32'({fb_valid, fb_addr, fb_data}), 32'(stall_val));
         if (fb_valid && fb_ready) begin
            obs_q.push_back({fb_addr, fb_data});
            last_xfer = cyc;
         end
         if (frame_done) begin
            fd_count++;
            fd_cycle = cyc;
         end
         stall_prev = fb_valid && !fb_ready;
         stall_val  = {fb_valid, fb_addr, fb_data};
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic vsync_pulse();
      lcd_vsync = 1'b1;
      step();
      lcd_vsync = 1'b0;
   endtask

   function automatic iq_t fill_cols(input int n, input int c);
      iq_t q;
      for (int i = 0; i < n; i++) q.push_back(c);
      return q;
   endfunction

   function automatic iq_t rand_cols(input int n);
      iq_t q;
      for (int i = 0; i < n; i++) q.push_back(int'($urandom_range(0, 3)));
      return q;
   endfunction

   task automatic send_line(input iq_t cols, input int gmax, input bit hs_with_last);
      for (int i = 0; i < cols.size(); i++) begin
         lcd_pixel = 1'b1;
         lcd_color = 2'(cols[i]);
         lcd_hsync = hs_with_last && (i == cols.size() - 1);
         step();
         lcd_pixel = 1'b0;
         lcd_hsync = 1'b0;
         if (gmax > 0) repeat ($urandom_range(0, gmax)) step();
      end
      if (!hs_with_last || cols.size() == 0) begin
         lcd_hsync = 1'b1;
         step();
         lcd_hsync = 1'b0;
      end
   endtask

   // Line-level reference: every started group of four pixels yields a byte.
   task automatic model_line(input iq_t cols, input int y, input int bank);
      int n;
      n = (cols.size() < H) ? cols.size() : H;
      for (int i = 0; 4 * i < n; i++) begin
         int b;
         b = 0;
         for (int k = 0; k < 4; k++)
            if (4 * i + k < n) b += cols[4 * i + k] << (2 * k);
         exp_q.push_back(22'((bank * 8192 + y * (H / 4) + i) * 256 + b));
      end
   endtask

   task automatic wait_idle(input string tag);
      int quiet;
      int budget;
      quiet  = 0;
      budget = 0;
      while (quiet < 4 && budget < 2000) begin
         step();
         budget++;
         if (!fb_valid) quiet++;
         else quiet = 0;
      end
      check(tag, 32'(budget < 2000), 32'd1);
   endtask

   task automatic compare(input string tag);
      int n;
      check({tag, "_count"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check(tag, 32'(obs_q[i]), 32'(exp_q[i]));
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, 32'(fb_valid), 32'd0);
      check({tag, "_addr"},  32'(fb_addr), 32'd0);
      check({tag, "_data"},  32'(fb_data), 32'd0);
      check({tag, "_disp"},  32'(disp_bank), 32'd0);
      check({tag, "_done"},  32'(frame_done), 32'd0);
      check({tag, "_err"},   32'(err_overrun), 32'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      iq_t cols;
      int  fd0;
      int  budget;

      // Reset state
      idle(3);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      idle(3);

      // 160 pixels of shade 2 -> 40 x 8'hAA at 0x2000..0x2027
      vsync_pulse();
      idle(2);
      cols = fill_cols(H, 2);
      send_line(cols, 0, 1'b0);
      model_line(cols, 0, 1);
      wait_idle("t1_drain");
      check("t1_first_word", 32'((obs_q.size() > 0) ? obs_q[0] : 22'd0), 32'({14'h2000, 8'hAA}));
      check("t1_last_word",  32'((obs_q.size() > 39) ? obs_q[39] : 22'd0), 32'({14'h2027, 8'hAA}));
      compare("t1");
      check("t1_err", 32'(err_overrun), 32'd0);

      // Short frame restart, 6-pixel line -> 8'h39 @0, 8'h09 @1, then y=1
      vsync_pulse();
      idle(2);
      cols = '{1, 2, 3, 0, 1, 2};
      send_line(cols, 2, 1'b0);
      model_line(cols, 0, 1);
      cols = rand_cols(4);
      send_line(cols, 1, 1'b0);
      model_line(cols, 1, 1);
      wait_idle("t4_drain");
      check("t4_byte0", 32'((obs_q.size() > 0) ? obs_q[0] : 22'd0), 32'({14'h2000, 8'h39}));
      check("t4_byte1", 32'((obs_q.size() > 1) ? obs_q[1] : 22'd0), 32'({14'h2001, 8'h09}));
      compare("t4");
      check("t4_no_swap_disp", 32'(disp_bank), 32'd0);
      check("t4_no_frame_done", fd_count, 0);

      // Pixel+hsync coincidence, then vsync masking pixel+hsync
      vsync_pulse();
      idle(2);
      cols = rand_cols(6);
      send_line(cols, 0, 1'b1);
      model_line(cols, 0, 1);
      cols = rand_cols(2);
      foreach (cols[i]) begin
         lcd_pixel = 1'b1;
         lcd_color = 2'(cols[i]);
         step();
      end
      lcd_vsync = 1'b1;
      lcd_hsync = 1'b1;
      lcd_color = 2'd3;
      step();
      lcd_vsync = 1'b0;
      lcd_hsync = 1'b0;
      lcd_pixel = 1'b0;
      idle(2);
      cols = rand_cols(4);
      send_line(cols, 1, 1'b0);
      model_line(cols, 0, 1);
      wait_idle("coinc_drain");
      compare("coinc");
      check("coinc_err", 32'(err_overrun), 32'd0);

      // 161 pixels: the extra one is dropped and flags the error
      vsync_pulse();
      idle(2);
      cols = rand_cols(H + 1);
      send_line(cols, 1, 1'b0);
      model_line(cols, 0, 1);
      wait_idle("t5_drain");
      compare("t5");
      check("t5_err_set", 32'(err_overrun), 32'd1);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      idle(1);
      check("t5_err_clr", 32'(err_overrun), 32'd0);

      // fb_ready low for a full line: only the first 8 bytes survive
      ready_fixed = 1'b0;
      idle(3);
      vsync_pulse();
      idle(2);
      cols = rand_cols(H);
      send_line(cols, 0, 1'b0);
      model_line(cols, 0, 1);
      while (exp_q.size() > 8) void'(exp_q.pop_back());
      idle(4);
      check("t3_valid_held", 32'(fb_valid), 32'd1);
      check("t3_err_set", 32'(err_overrun), 32'd1);
      check("t3_head", 32'({fb_addr, fb_data}), 32'(exp_q[0]));
      check("t3_none_yet", obs_q.size(), 0);
      ready_mode = 1;
      wait_idle("t3_drain");
      compare("t3");
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      idle(1);
      check("t3_err_clr", 32'(err_overrun), 32'd0);

      // Full frame, lines alternating shade 0 and 3, random stalls
      vsync_pulse();
      idle(2);
      fd0 = fd_count;
      for (int l = 0; l < V; l++) begin
         cols = fill_cols(H, (l % 2 == 1) ? 3 : 0);
         send_line(cols, 0, 1'b0);
         model_line(cols, l, 1);
      end
      budget = 0;
      while (fd_count == fd0 && budget < 3000) begin
         step();
         budget++;
      end
      check("t2_done_seen", 32'(budget < 3000), 32'd1);
      idle(4);
      check("t2_done_once", fd_count - fd0, 1);
      check("t2_done_after_last_write", 32'(fd_cycle > last_xfer), 32'd1);
      check("t2_disp_bank", 32'(disp_bank), 32'd1);
      check("t2_err", 32'(err_overrun), 32'd0);
      compare("t2");

      // Next frame lands in bank 0
      vsync_pulse();
      idle(2);
      cols = rand_cols(H);
      send_line(cols, 0, 1'b0);
      model_line(cols, 0, 0);
      wait_idle("nf_drain");
      check("nf_first_addr", 32'((obs_q.size() > 0) ? obs_q[0][21:8] : 14'h3fff), 32'h0000);
      compare("nf");

      // Lines up to 70, vsync, then reset mid-line
      ready_mode = 0;
      ready_fixed = 1'b1;
      for (int l = 1; l < 70; l++) begin
         cols = rand_cols(H);
         send_line(cols, 0, 1'b0);
         model_line(cols, l, 0);
      end
      fd0 = fd_count;
      vsync_pulse();
      idle(1);
      cols = rand_cols(8);
      foreach (cols[i]) begin
         lcd_pixel = 1'b1;
         lcd_color = 2'(cols[i]);
         step();
      end
      lcd_pixel = 1'b0;
      model_line(cols, 0, 0);
      wait_idle("t6_drain");
      compare("t6");
      cols = rand_cols(3);
      foreach (cols[i]) begin
         lcd_pixel = 1'b1;
         lcd_color = 2'(cols[i]);
         step();
      end
      lcd_pixel = 1'b0;
      check("t6_disp_before_rst", 32'(disp_bank), 32'd1);
      rst_n = 1'b0;
      idle(2);
      check_reset_outputs("t6_in_rst");
      rst_n = 1'b1;
      idle(1);
      check_reset_outputs("t6_post_rst");
      check("t6_no_frame_done", fd_count - fd0, 0);

      // Back in WAIT_FRAME: a line without vsync produces nothing
      cols = rand_cols(8);
      send_line(cols, 0, 1'b0);
      idle(6);
      check("wait_ignores_valid", 32'(fb_valid), 32'd0);
      check("wait_ignores_writes", obs_q.size(), 0);

      // After vsync, writes go to bank 1 again
      vsync_pulse();
      idle(2);
      cols = rand_cols(4);
      send_line(cols, 0, 1'b0);
      model_line(cols, 0, 1);
      wait_idle("post_rst_drain");
      compare("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
